rotate_cmd_ctrl: RTL and testbench

Command sequencer that sits directly upstream of the right-rotate register and drives its `load`, `en` and `data` inputs. It accepts (word, rotate-count) commands over a valid/ready handshake and buffers them in a small FIFO. For each command it issues one load cycle and then exactly the requested number of rotate-enable cycles, followed by a one-cycle `done` pulse.

---
 rtl/rotate_pkg.sv | 16 +
 rtl/rotate_cmd_fifo.sv | 82 ++++++++
 rtl/rotate_cmd_ctrl.sv | 145 ++++++++++++++
 tb/tb_rotate_cmd_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rotate_pkg.sv
// rotate_pkg: shared constants and FSM state encoding for the rotate command sequencer.
package rotate_pkg;

  // Default widths; DW must match the downstream rotate register.
  localparam int unsigned ROT_DW = 4;
  localparam int unsigned ROT_CW = 4;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ROTATE = 2'd2,
    ST_DONE   = 2'd3
  } rot_state_e;

endpackage : rotate_pkg

// File: rtl/rotate_cmd_fifo.sv
// rotate_cmd_fifo: synchronous command FIFO, W bits wide, DEPTH (power of two) entries.
// Push when full and pop when empty are ignored internally; pointers wrap modulo DEPTH.
module rotate_cmd_fifo
  import rotate_pkg::*;
#(
  parameter int unsigned W     = ROT_DW + ROT_CW,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         sync_rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = AW + 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            push_ok;
  logic            pop_ok;

  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & ~empty_q;

  // Pointer, occupancy and flag next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNTW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Control state registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule : rotate_cmd_fifo

// File: rtl/rotate_cmd_ctrl.sv
// rotate_cmd_ctrl: buffers (word, count) commands and drives load/en/data of a
// downstream right-rotate register: one load cycle, N enable cycles, one done pulse.
// Optional feature macro: ROT_MOD_EN -- effective count becomes in_cnt mod DW.
module rotate_cmd_ctrl
  import rotate_pkg::*;
#(
  parameter int unsigned DW    = ROT_DW,
  parameter int unsigned CW    = ROT_CW,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          sync_rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [CW-1:0] in_cnt,
  output logic          load,
  output logic          en,
  output logic [DW-1:0] data,
  output logic          busy,
  output logic          done
);

  localparam int unsigned FW = DW + CW;

  rot_state_e    state_q, state_d;
  logic [DW-1:0] cmd_data_q, cmd_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_q, load_d;
  logic          en_q, en_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic          fifo_full;
  logic          fifo_empty;
  logic [FW-1:0] fifo_rdata;
  logic [DW-1:0] head_data;
  logic [CW-1:0] head_cnt;
  logic [CW-1:0] eff_cnt_c;
  logic          push_c;
  logic          pop_c;

  assign in_ready  = ~fifo_full;
  assign push_c    = in_valid & ~fifo_full;
  assign head_data = fifo_rdata[FW-1:CW];
  assign head_cnt  = fifo_rdata[CW-1:0];

  // A new command is taken whenever the sequencer is between commands.
  assign pop_c = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && !fifo_empty;

`ifdef ROT_MOD_EN
  // Whole-word rotations are redundant; keep only count mod DW (DW power of two).
  assign eff_cnt_c = head_cnt & CW'(DW - 1);
`else
  assign eff_cnt_c = head_cnt;
`endif

  rotate_cmd_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .sync_rst (sync_rst),
    .push_i   (push_c),
    .wdata_i  ({in_data, in_cnt}),
    .pop_i    (pop_c),
    .rdata_o  (fifo_rdata),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // Next-state logic plus command/count datapath.
  always_comb begin
    state_d    = state_q;
    cmd_data_d = cmd_data_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = (cnt_q == '0) ? ST_DONE : ST_ROTATE;
      end
      ST_ROTATE: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = fifo_empty ? ST_IDLE : ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop_c) begin
      cmd_data_d = head_data;
      cnt_d      = eff_cnt_c;
    end
  end

  // Moore output decode of the upcoming state, so outputs come straight from flops.
  always_comb begin
    load_d = 1'b0;
    en_d   = 1'b0;
    done_d = 1'b0;
    busy_d = 1'b1;
    case (state_d)
      ST_IDLE:   busy_d = 1'b0;
      ST_LOAD:   load_d = 1'b1;
      ST_ROTATE: en_d   = 1'b1;
      ST_DONE:   done_d = 1'b1;
      default:   busy_d = 1'b0;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q    <= ST_IDLE;
      cmd_data_q <= '0;
      cnt_q      <= '0;
      load_q     <= 1'b0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_data_q <= cmd_data_d;
      cnt_q      <= cnt_d;
      load_q     <= load_d;
      en_q       <= en_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign load = load_q;
  assign en   = en_q;
  assign done = done_q;
  assign busy = busy_q;
  assign data = cmd_data_q;

endmodule : rotate_cmd_ctrl

// File: tb/tb_rotate_cmd_ctrl.sv
// Self-checking bench for rotate_cmd_ctrl against a command-queue reference model.
module tb_rotate_cmd_ctrl;

  localparam int unsigned DW    = 4;
  localparam int unsigned CW    = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned VW    = DW + 5;

  logic          clk = 1'b0;
  logic          sync_rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_cnt;
  logic          load;
  logic          en;
  logic [DW-1:0] data;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  rotate_cmd_ctrl #(.DW(DW), .CW(CW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .sync_rst (sync_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_cnt   (in_cnt),
    .load     (load),
    .en       (en),
    .data     (data),
    .busy     (busy),
    .done     (done)
  );

  // Downstream right-rotate register driven by the DUT.
  logic [DW-1:0] q_ds;
  always @(posedge clk) begin
    if (load)    q_ds <= data;
    else if (en) q_ds <= {q_ds[0], q_ds[DW-1:1]};
  end

  typedef struct {
    logic [DW-1:0] d;
    int unsigned   n;
  } cmd_t;

  typedef struct packed {
    logic          load;
    logic          en;
    logic          done;
    logic [DW-1:0] data;
  } ev_t;

  cmd_t m_cmds[$];
  ev_t  m_sched[$];
  ev_t  m_cur;
  int   errors = 0;
  int   checks = 0;

  function automatic int unsigned eff_cnt(input int unsigned c);
`ifdef ROT_MOD_EN
    return c % DW;
`else
    return c;
`endif
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic b;
    b = m_cur.load | m_cur.en | m_cur.done;
    return {m_cur.load, m_cur.en, m_cur.done, b, (m_cmds.size() < int'(DEPTH)), m_cur.data};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {load, en, done, busy, in_ready, data};
  endfunction

  function automatic bit m_idle();
    return (m_cmds.size() == 0) && (m_sched.size() == 0) && !m_cur.load && !m_cur.en && !m_cur.done;
  endfunction

  // One clock edge: advance the reference model with the inputs seen at the edge.
  task automatic tick();
    cmd_t h;
    bit   push_ok;
    @(posedge clk);
    if (sync_rst) begin
      m_cmds.delete();
      m_sched.delete();
      m_cur = '0;
    end else begin
      push_ok = in_valid && (m_cmds.size() < int'(DEPTH));
      if (m_sched.size() == 0 && m_cmds.size() > 0) begin
        h = m_cmds.pop_front();
        m_sched.push_back('{1'b1, 1'b0, 1'b0, h.d});
        for (int i = 0; i < int'(h.n); i++) m_sched.push_back('{1'b0, 1'b1, 1'b0, h.d});
        m_sched.push_back('{1'b0, 1'b0, 1'b1, h.d});
      end
      if (m_sched.size() > 0) m_cur = m_sched.pop_front();
      else                    m_cur = '{1'b0, 1'b0, 1'b0, m_cur.data};
      if (push_ok) m_cmds.push_back('{in_data, eff_cnt(32'(in_cnt))});
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = v;
    in_data  = d;
    in_cnt   = c;
  endtask

  task automatic test_reset();
    sync_rst = 1'b1;
    drive(1'b1, 4'hA, 4'h2);
    repeat (2) begin
      tick();
      checks++;
      if (obs_vec() !== {5'b00001, {DW{1'b0}}}) begin
        errors++;
        $display("FAIL reset_state got=%b exp=%b", obs_vec(), {5'b00001, {DW{1'b0}}});
      end
    end
    sync_rst = 1'b0;
    drive(1'b0, '0, '0);
    repeat (2) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_push_ignored got=%b exp=%b", obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_basic();
    int n_en = 0, n_ld = 0, n_dn = 0;
    drive(1'b1, 4'b1001, 4'd3);
    tick();
    drive(1'b0, '0, '0);
    repeat (7) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL basic_cycle t=%0t got=%b exp=%b", $time, obs_vec(), exp_vec());
      end
      if (en)   n_en++;
      if (load) n_ld++;
      if (done) n_dn++;
    end
    checks++;
    if (n_en != 3 || n_ld != 1 || n_dn != 1) begin
      errors++;
      $display("FAIL basic_counts got en=%0d ld=%0d dn=%0d exp en=3 ld=1 dn=1", n_en, n_ld, n_dn);
    end
    checks++;
    if (q_ds !== 4'b0011) begin
      errors++;
      $display("FAIL basic_rotated got=%b exp=0011", q_ds);
    end
  endtask

  task automatic test_zero_count();
    int n_en = 0, ld_at = -1, dn_at = -1;
    drive(1'b1, 4'b0110, 4'd0);
    tick();
    drive(1'b0, '0, '0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL zero_cycle t=%0t got=%b exp=%b", $time, obs_vec(), exp_vec());
      end
      if (en)   n_en++;
      if (load) ld_at = k;
      if (done) dn_at = k;
    end
    checks++;
    if (n_en != 0 || ld_at < 0 || dn_at != ld_at + 1) begin
      errors++;
      $display("FAIL zero_seq got en=%0d ld_at=%0d dn_at=%0d exp en=0 dn_at=ld_at+1", n_en, ld_at, dn_at);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] ds[3] = '{4'hA, 4'h5, 4'hC};
    logic [CW-1:0] cs[3] = '{4'd2, 4'd1, 4'd3};
    logic [DW-1:0] loaded[$];
    int  i = 0, k = 0, gaps = 0, n_dn = 0;
    bit  acc, saw_full = 0, started = 0;
    while (!(i == 3 && m_idle()) && k < 80) begin
      if (i < 3) drive(1'b1, ds[i], cs[i]);
      else       drive(1'b0, '0, '0);
      acc = in_valid && in_ready;
      tick();
      k++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL b2b_cycle t=%0t got=%b exp=%b", $time, obs_vec(), exp_vec());
      end
      if (acc) i++;
      if (!in_ready) saw_full = 1;
      if (load) begin loaded.push_back(data); started = 1; end
      if (done) n_dn++;
      if (started && n_dn < 3 && !busy) gaps++;
    end
    drive(1'b0, '0, '0);
    checks++;
    if (k >= 80) begin
      errors++;
      $display("FAIL b2b_timeout got cycles=%0d exp <80", k);
    end
    checks++;
    if (!saw_full || gaps != 0 || n_dn != 3) begin
      errors++;
      $display("FAIL b2b_flow got full=%0d gaps=%0d done=%0d exp full=1 gaps=0 done=3", saw_full, gaps, n_dn);
    end
    checks++;
    if (loaded.size() != 3 || loaded[0] !== ds[0] || loaded[1] !== ds[1] || loaded[2] !== ds[2]) begin
      errors++;
      $display("FAIL b2b_order got n=%0d exp A,5,C in order", loaded.size());
    end
  endtask

  task automatic test_reset_mid();
    int k = 0, n_dn = 0;
    drive(1'b1, 4'h9, 4'd7);
    tick();
    drive(1'b1, 4'h6, 4'd4);
    tick();
    drive(1'b0, '0, '0);
    while (en !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    checks++;
    if (k >= 20) begin
      errors++;
      $display("FAIL rstmid_no_rotate got en=%b exp en=1 within 20 cycles", en);
    end
    sync_rst = 1'b1;
    tick();
    sync_rst = 1'b0;
    checks++;
    if (obs_vec() !== {5'b00001, {DW{1'b0}}}) begin
      errors++;
      $display("FAIL rstmid_state got=%b exp=%b", obs_vec(), {5'b00001, {DW{1'b0}}});
    end
    repeat (6) begin
      tick();
      if (done) n_dn++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rstmid_after t=%0t got=%b exp=%b", $time, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (n_dn != 0) begin
      errors++;
      $display("FAIL rstmid_done got=%0d exp=0", n_dn);
    end
  endtask

  task automatic test_mod_count();
    int n_en = 0;
`ifdef ROT_MOD_EN
    int exp_en = 1;
`else
    int exp_en = 5;
`endif
    drive(1'b1, 4'b1110, 4'd5);
    tick();
    drive(1'b0, '0, '0);
    repeat (10) begin
      tick();
      if (en) n_en++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL mod_cycle t=%0t got=%b exp=%b", $time, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (n_en != exp_en) begin
      errors++;
      $display("FAIL mod_en_count got=%0d exp=%0d", n_en, exp_en);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      sync_rst = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 1) == 1), DW'($urandom), CW'($urandom));
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_cycle k=%0d got=%b exp=%b", k, obs_vec(), exp_vec());
      end
      checks++;
      if (load && en) begin
        errors++;
        $display("FAIL random_exclusive k=%0d got load=1 en=1 exp not both", k);
      end
    end
    sync_rst = 1'b0;
    drive(1'b0, '0, '0);
  endtask

  initial begin
    m_cur    = '0;
    sync_rst = 1'b1;
    drive(1'b0, '0, '0);
    test_reset();
    test_basic();
    test_zero_count();
    test_back_to_back();
    test_reset_mid();
    test_mod_count();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rotate_cmd_ctrl
